// File: rtl/score_recorder.sv
// score_recorder: per-{user,song} score book for the learning mode.
// On a qualifying rising edge of `finished`, a fixed four-cycle commit runs
// (IDLE -> CAPTURE -> COMPARE -> WRITE -> IDLE). It updates best, last and
// attempts for the latched index.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mode            operating mode, 3'b111 = learning
//   user, song_num  display index and commit index source
//   finished, score session-done level and its score
//   clear_all       one-cycle erase of all records, aborts any commit
//   best_score, last_score, attempts, has_record  registered view of {user,song_num}
//   new_record      one-cycle pulse after a WRITE that set a new best
//   busy            commit in progress
module score_recorder #(
  parameter int unsigned SCORE_W = 33,
  parameter int unsigned ATT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         mode,
  input  logic [1:0]         user,
  input  logic [1:0]         song_num,
  input  logic               finished,
  input  logic [SCORE_W-1:0] score,
  input  logic               clear_all,
  output logic [SCORE_W-1:0] best_score,
  output logic [SCORE_W-1:0] last_score,
  output logic [ATT_W-1:0]   attempts,
  output logic               has_record,
  output logic               new_record,
  output logic               busy
);

  localparam int unsigned ENTRIES = 16;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;
  localparam logic [2:0] MODE_LEARN = 3'b111;
  localparam logic [ATT_W-1:0] ATT_MAX = '1;

  logic [1:0]         state, state_nxt;
  logic               finished_q;
  logic               armed;
  logic [SCORE_W-1:0] lat_score;
  logic [3:0]         lat_idx;
  logic               is_best;

  logic [ENTRIES-1:0] ent_valid;
  logic [SCORE_W-1:0] ent_best [ENTRIES];
  logic [SCORE_W-1:0] ent_last [ENTRIES];
  logic [ATT_W-1:0]   ent_att  [ENTRIES];

  logic               start_c;
  logic               wr_en_c;
  logic [ATT_W-1:0]   att_inc_c;
  logic [3:0]         rd_idx_c;

  // `armed` blocks a finished level that was already high when reset released
  assign start_c   = (state == IDLE) && finished && !finished_q && armed &&
                     (mode == MODE_LEARN) && !clear_all;
  assign wr_en_c   = (state == WRITE) && !clear_all;
  assign att_inc_c = (ent_att[lat_idx] == ATT_MAX) ? ATT_MAX
                                                   : ent_att[lat_idx] + ATT_W'(1);
  assign rd_idx_c  = {user, song_num};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear_all aborts from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_c) state_nxt = CAPTURE;
      CAPTURE: state_nxt = COMPARE;
      COMPARE: state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_all) state_nxt = IDLE;
  end

  // Edge history, commit latches and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      finished_q <= 1'b0;
      armed      <= 1'b0;
      lat_score  <= '0;
      lat_idx    <= '0;
      is_best    <= 1'b0;
      busy       <= 1'b0;
      new_record <= 1'b0;
    end else begin
      finished_q <= finished;
      armed      <= armed | ~finished;
      if (start_c) begin
        lat_score <= score;
        lat_idx   <= rd_idx_c;
      end
      if (state == COMPARE)
        is_best <= !ent_valid[lat_idx] || (lat_score > ent_best[lat_idx]);
      busy       <= (state_nxt != IDLE);
      new_record <= wr_en_c && is_best;
    end
  end

  // Valid bits and attempt counters: reset and clear_all erase them
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      ent_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ent_att[i] <= '0;
    end else if (wr_en_c) begin
      ent_valid[lat_idx] <= 1'b1;
      ent_att[lat_idx]   <= att_inc_c;
    end
  end

  // Score storage; contents are only meaningful when the entry is valid
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      ent_last[lat_idx] <= lat_score;
      if (is_best) ent_best[lat_idx] <= lat_score;
    end
  end

  // Registered read port with bypass so a WRITE shows up the very next cycle
  always_ff @(posedge clk) begin
    if (rst || clear_all) begin
      best_score <= '0;
      last_score <= '0;
      attempts   <= '0;
      has_record <= 1'b0;
    end else if (wr_en_c && (lat_idx == rd_idx_c)) begin
      best_score <= is_best ? lat_score : ent_best[rd_idx_c];
      last_score <= lat_score;
      attempts   <= att_inc_c;
      has_record <= 1'b1;
    end else if (ent_valid[rd_idx_c]) begin
      best_score <= ent_best[rd_idx_c];
      last_score <= ent_last[rd_idx_c];
      attempts   <= ent_att[rd_idx_c];
      has_record <= 1'b1;
    end else begin
      best_score <= '0;
      last_score <= '0;
      attempts   <= '0;
      has_record <= 1'b0;
    end
  end

endmodule
